// File: rtl/servo_arb_pkg.sv
// Shared encodings for servo_move_arbiter: FSM states, tracked position,
// move-counter width and default duty codes.
package servo_arb_pkg;

    localparam int CNT_W  = 27;
    localparam int DUTY_W = 10;

    localparam int DEF_DUTY_OPEN  = 68;
    localparam int DEF_DUTY_CLOSE = 20;
    localparam int DEF_DUTY_HOLD  = 45;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_MOVING,
        ST_SETTLE
    } arb_state_t;

    typedef enum logic [1:0] {
        POS_UNKNOWN = 2'b00,
        POS_OPEN    = 2'b01,
        POS_CLOSED  = 2'b10
    } pos_t;

    // Requested direction (1 = close, 0 = open) to the position it ends at.
    function automatic pos_t dir_to_pos(input logic dir);
        return dir ? POS_CLOSED : POS_OPEN;
    endfunction

endpackage

// File: rtl/servo_rr_arbiter.sv
// Combinational round-robin pick: first requester strictly after `last`,
// wrapping to index 0.
module servo_rr_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int IDX_W   = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IDX_W-1:0]   last,
    output logic [NUM_REQ-1:0] winner,
    output logic               valid
);

    logic found;

    // Upper pass covers indices above the pointer, lower pass handles the wrap.
    always_comb begin
        winner = '0;
        found  = 1'b0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            if (!found && req[i] && (i > 32'(last))) begin
                winner[i] = 1'b1;
                found     = 1'b1;
            end
        end
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            if (!found && req[i]) begin
                winner[i] = 1'b1;
                found     = 1'b1;
            end
        end
        valid = |req;
    end

endmodule

// File: rtl/servo_move_arbiter.sv
// Round-robin arbiter granting exclusive servo moves; drives duty code and tracks position.
// Optional SERVO_ARB_INPUT_FILTER_EN: 2-flop sync + 3-sample filter on req/req_dir (+4 cycles).
module servo_move_arbiter
    import servo_arb_pkg::*;
#(
    parameter int NUM_REQ     = 4,
    parameter int MOVE_CYCLES = 80000000,
    parameter int DUTY_OPEN   = DEF_DUTY_OPEN,
    parameter int DUTY_CLOSE  = DEF_DUTY_CLOSE,
    parameter int DUTY_HOLD   = DEF_DUTY_HOLD
) (
    input  logic               clk25mhz,
    input  logic               reset,
    input  logic [NUM_REQ-1:0] req,
    input  logic [NUM_REQ-1:0] req_dir,
    output logic [NUM_REQ-1:0] gnt,
    output logic [NUM_REQ-1:0] done,
    output logic               busy,
    output logic [DUTY_W-1:0]  duty_cycle,
    output logic [1:0]         pos
);

    localparam int IDX_W = $clog2(NUM_REQ);

    localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(MOVE_CYCLES - 1);
    localparam logic [DUTY_W-1:0] OPEN_C   = DUTY_W'(DUTY_OPEN);
    localparam logic [DUTY_W-1:0] CLOSE_C  = DUTY_W'(DUTY_CLOSE);
    localparam logic [DUTY_W-1:0] HOLD_C   = DUTY_W'(DUTY_HOLD);

    logic [NUM_REQ-1:0] arb_req;
    logic [NUM_REQ-1:0] arb_dir;

`ifdef SERVO_ARB_INPUT_FILTER_EN
    logic [NUM_REQ-1:0] req_s1, req_s2, req_h1, req_h2;
    logic [NUM_REQ-1:0] dir_s1, dir_s2;

    always_ff @(posedge clk25mhz) begin
        if (reset) begin
            req_s1 <= '0;
            req_s2 <= '0;
            req_h1 <= '0;
            req_h2 <= '0;
            dir_s1 <= '0;
            dir_s2 <= '0;
        end else begin
            req_s1 <= req;
            req_s2 <= req_s1;
            req_h1 <= req_s2;
            req_h2 <= req_h1;
            dir_s1 <= req_dir;
            dir_s2 <= dir_s1;
        end
    end

    // The synchronizer output is the newest of the three filter samples.
    assign arb_req = req_s2 & req_h1 & req_h2;
    assign arb_dir = dir_s2;
`else
    assign arb_req = req;
    assign arb_dir = req_dir;
`endif

    arb_state_t         state, state_nxt;
    logic [CNT_W-1:0]   cnt, cnt_nxt;
    logic [NUM_REQ-1:0] gnt_nxt, done_nxt;
    logic               busy_nxt;
    logic [DUTY_W-1:0]  duty_nxt;
    logic [1:0]         pos_nxt;
    logic               dir_q, dir_nxt;
    logic [IDX_W-1:0]   last_idx, last_nxt;

    logic [NUM_REQ-1:0] win_onehot;
    logic               win_valid;
    logic [IDX_W-1:0]   win_idx;

    servo_rr_arbiter #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (IDX_W)
    ) u_rr (
        .req    (arb_req),
        .last   (last_idx),
        .winner (win_onehot),
        .valid  (win_valid)
    );

    always_comb begin
        win_idx = '0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            if (win_onehot[i]) win_idx = IDX_W'(i);
        end
    end

    always_ff @(posedge clk25mhz) begin
        if (reset) begin
            state      <= ST_IDLE;
            cnt        <= '0;
            gnt        <= '0;
            done       <= '0;
            busy       <= 1'b0;
            duty_cycle <= HOLD_C;
            pos        <= POS_UNKNOWN;
            dir_q      <= 1'b0;
            last_idx   <= IDX_W'(NUM_REQ - 1);
        end else begin
            state      <= state_nxt;
            cnt        <= cnt_nxt;
            gnt        <= gnt_nxt;
            done       <= done_nxt;
            busy       <= busy_nxt;
            duty_cycle <= duty_nxt;
            pos        <= pos_nxt;
            dir_q      <= dir_nxt;
            last_idx   <= last_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        gnt_nxt   = gnt;
        dir_nxt   = dir_q;
        last_nxt  = last_idx;
        pos_nxt   = pos;

        // IDLE first grants, then on the following cycle routes on the latched direction.
        unique case (state)
            ST_IDLE: begin
                cnt_nxt = '0;
                if (gnt == '0) begin
                    if (win_valid) begin
                        gnt_nxt  = win_onehot;
                        dir_nxt  = |(arb_dir & win_onehot);
                        last_nxt = win_idx;
                    end
                end else if (dir_to_pos(dir_q) == pos) begin
                    state_nxt = ST_SETTLE;
                end else begin
                    state_nxt = ST_MOVING;
                end
            end
            ST_MOVING: begin
                if (cnt == CNT_LAST) state_nxt = ST_SETTLE;
                else                 cnt_nxt   = cnt + 1'b1;
            end
            ST_SETTLE: begin
                state_nxt = ST_IDLE;
                gnt_nxt   = '0;
            end
            default: begin
                state_nxt = ST_IDLE;
                gnt_nxt   = '0;
            end
        endcase

        // Outputs are registered against the state being entered.
        busy_nxt = (state_nxt != ST_IDLE);
        done_nxt = (state_nxt == ST_SETTLE) ? gnt_nxt : '0;
        duty_nxt = HOLD_C;
        if (state_nxt == ST_MOVING) duty_nxt = dir_nxt ? CLOSE_C : OPEN_C;
        if (state_nxt == ST_SETTLE) pos_nxt  = dir_to_pos(dir_nxt);
    end

endmodule

// File: tb/tb_servo_move_arbiter.sv
// Self-checking bench for servo_move_arbiter with a transaction-level reference model.
module tb_servo_move_arbiter;

    localparam int NREQ = 4;
    localparam int MOVE = 8;

    logic       clk = 1'b0;
    logic       reset;
    logic [3:0] req;
    logic [3:0] req_dir;
    logic [3:0] gnt;
    logic [3:0] done;
    logic       busy;
    logic [9:0] duty_cycle;
    logic [1:0] pos;

    int checks = 0;
    int errors = 0;

    // Reference state: position (0 unknown, 1 open, 2 closed), last grant, pending set.
    int         m_pos;
    int         m_last;
    logic [3:0] pend;

    servo_move_arbiter #(
        .NUM_REQ     (NREQ),
        .MOVE_CYCLES (MOVE)
    ) dut (
        .clk25mhz   (clk),
        .reset      (reset),
        .req        (req),
        .req_dir    (req_dir),
        .gnt        (gnt),
        .done       (done),
        .busy       (busy),
        .duty_cycle (duty_cycle),
        .pos        (pos)
    );

    always #20 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic int rr_pick(input logic [3:0] r, input int last);
        for (int k = 1; k <= NREQ; k++) begin
            int idx;
            idx = (last + k) % NREQ;
            if (r[idx]) return idx;
        end
        return -1;
    endfunction

    // Called at an idle negedge with req already driven; follows one full transaction.
    task automatic run_txn(input bit drop, input bit toggle, input bit noise);
        int         w;
        logic       d;
        bit         moves;
        logic [3:0] oh;
        w = rr_pick(req, m_last);
        if (w < 0) begin
            errors++;
            $display("FAIL run_txn: observed no pending request, required at least one");
            return;
        end
        oh    = 4'(1 << w);
        d     = req_dir[w];
        moves = !((d && m_pos == 2) || (!d && m_pos == 1));

        @(negedge clk);
        chk("grant_gnt", 32'(gnt), 32'(oh));
        chk("grant_busy", 32'(busy), 0);
        chk("grant_duty", 32'(duty_cycle), 45);
        chk("grant_done", 32'(done), 0);

        if (moves) begin
            for (int c = 0; c < MOVE; c++) begin
                @(negedge clk);
                chk("move_gnt", 32'(gnt), 32'(oh));
                chk("move_duty", 32'(duty_cycle), d ? 20 : 68);
                chk("move_busy", 32'(busy), 1);
                chk("move_done", 32'(done), 0);
                if (toggle && c == 2) req_dir[w] = ~req_dir[w];
                if (noise) req = pend | 4'($urandom_range(0, 15));
            end
        end

        @(negedge clk);
        chk("settle_done", 32'(done), 32'(oh));
        chk("settle_gnt", 32'(gnt), 32'(oh));
        chk("settle_duty", 32'(duty_cycle), 45);
        chk("settle_busy", 32'(busy), 1);
        m_pos  = d ? 2 : 1;
        m_last = w;
        if (drop) pend[w] = 1'b0;
        req = pend;

        @(negedge clk);
        chk("idle_gnt", 32'(gnt), 0);
        chk("idle_done", 32'(done), 0);
        chk("idle_busy", 32'(busy), 0);
        chk("idle_duty", 32'(duty_cycle), 45);
        chk("idle_pos", 32'(pos), 32'(m_pos));
    endtask

    initial begin
        reset   = 1'b1;
        req     = '0;
        req_dir = '0;
        pend    = '0;
        m_pos   = 0;
        m_last  = NREQ - 1;
        repeat (3) @(negedge clk);
        chk("rst_gnt", 32'(gnt), 0);
        chk("rst_done", 32'(done), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_duty", 32'(duty_cycle), 45);
        chk("rst_pos", 32'(pos), 0);
        reset = 1'b0;

`ifdef SERVO_ARB_INPUT_FILTER_EN
        // Two-cycle glitch must never reach the arbiter.
        req = 4'b0001; req_dir = 4'b0001;
        @(negedge clk);
        @(negedge clk);
        req = 4'b0000;
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            chk("glitch_gnt", 32'(gnt), 0);
        end
        req = 4'b0001;
        begin
            int lat;
            lat = 0;
            while (gnt == 4'b0000 && lat < 20) begin
                @(negedge clk);
                lat++;
            end
            chk("filter_latency", 32'(lat), 5);
            chk("filter_gnt", 32'(gnt), 1);
        end
        req = 4'b0000;
        repeat (20) @(negedge clk);
        chk("filter_end_busy", 32'(busy), 0);
`else
        // Close from unknown position on requester 0.
        pend = 4'b0001; req = 4'b0001; req_dir = 4'b0001;
        run_txn(1'b1, 1'b0, 1'b0);

        // All four held: order 1, 2, 3, 0 with alternating directions.
        pend = 4'b1111; req = 4'b1111; req_dir = 4'b0101;
        for (int t = 0; t < 4; t++) begin
            if (t == 3) pend = 4'b0000;
            run_txn(1'b0, 1'b0, 1'b0);
        end

        // Already closed: straight to settle.
        pend = 4'b0100; req = 4'b0100; req_dir = 4'b0100;
        run_txn(1'b1, 1'b0, 1'b0);

        // Direction input flipped mid-move is ignored.
        pend = 4'b0001; req = 4'b0001; req_dir = 4'b0000;
        run_txn(1'b1, 1'b1, 1'b0);

        for (int t = 0; t < 40; t++) begin
            for (int i = 0; i < NREQ; i++) begin
                if (!pend[i] && $urandom_range(0, 1) != 0) begin
                    pend[i]    = 1'b1;
                    req_dir[i] = 1'($urandom_range(0, 1));
                end
            end
            if (pend == 4'b0000) begin
                int k;
                k          = int'($urandom_range(0, NREQ - 1));
                pend[k]    = 1'b1;
                req_dir[k] = 1'($urandom_range(0, 1));
            end
            req = pend;
            run_txn(1'b1, $urandom_range(0, 3) == 0, 1'b1);
        end

        // Reset while moving with the counter at 4.
        pend = 4'b0001; req = 4'b0001;
        req_dir[0] = (m_pos == 2) ? 1'b0 : 1'b1;
        @(negedge clk);
        chk("mid_rst_grant", 32'(gnt), 1);
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            chk("mid_rst_duty", 32'(duty_cycle), req_dir[0] ? 20 : 68);
        end
        reset = 1'b1;
        @(negedge clk);
        chk("mid_rst_gnt", 32'(gnt), 0);
        chk("mid_rst_duty_hold", 32'(duty_cycle), 45);
        chk("mid_rst_pos", 32'(pos), 0);
        chk("mid_rst_busy", 32'(busy), 0);
        chk("mid_rst_done", 32'(done), 0);
        reset  = 1'b0;
        req    = '0;
        pend   = '0;
        m_pos  = 0;
        m_last = NREQ - 1;
        @(negedge clk);

        // After reset index 0 has first priority among simultaneous requests.
        pend = 4'b1111; req = 4'b1111;
        req_dir = 4'($urandom_range(0, 15));
        for (int t = 0; t < 4; t++) run_txn(1'b1, 1'b0, 1'b0);
        chk("final_req_drained", 32'(gnt | done), 0);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
